// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin arbiter producing a registered one-hot mux select.
// A grant is held for a whole multi-beat transaction and is released only when
// the downstream acks the final (eop) beat. On release the grant moves straight
// to the next winner with no idle cycle. The releasing requester becomes the
// lowest priority.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      per-requester request level              [CNT]
//   ack      downstream accepted the current beat
//   eop      accepted beat is the last of the transaction (ignored when ack=0)
//   gnt      registered one-hot grant / mux select    [CNT]
//   gnt_vld  registered, high when gnt is non-zero
//   gnt_id   registered binary index of the grant     [IDW]
//   err      sticky flag: granted requester dropped req before its release
module rr_sel_arbiter #(
  parameter int unsigned CNT = 5,
  parameter int unsigned IDW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CNT-1:0] req,
  input  logic           ack,
  input  logic           eop,
  output logic [CNT-1:0] gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id,
  output logic           err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]     r_state;
  logic [IDW-1:0] r_ptr;
  logic [CNT-1:0] r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic           r_gnt_vld;
  logic           r_err;

  logic [0:0]     w_state_nxt;
  logic [IDW-1:0] w_ptr_nxt;
  logic [CNT-1:0] w_gnt_nxt;
  logic [IDW-1:0] w_gnt_id_nxt;
  logic           w_gnt_vld_nxt;
  logic           w_err_nxt;

  logic           w_release;
  logic [IDW-1:0] w_ptr_rel;
  logic [IDW-1:0] w_ptr_scan;
  logic [CNT-1:0] w_masked;
  logic [IDW-1:0] w_winner;
  logic [CNT-1:0] w_onehot;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDW-1:0] f_lsb(input logic [CNT-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = CNT - 1; i >= 0; i--) begin
      if (v[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  assign w_release = (r_state == ST_BUSY) && ack && eop;

  // Pointer after release: one past the current owner, wrapping at CNT-1.
  assign w_ptr_rel = (r_gnt_id == IDW'(CNT - 1)) ? '0 : r_gnt_id + IDW'(1);

  // Re-arbitration on release already uses the advanced pointer.
  assign w_ptr_scan = w_release ? w_ptr_rel : r_ptr;

  // Requests at or above the pointer; fall back to all requests for wrap-around.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < CNT; i++) begin
      w_masked[i] = req[i] && (IDW'(i) >= w_ptr_scan);
    end
  end

  assign w_winner = (|w_masked) ? f_lsb(w_masked) : f_lsb(req);
  assign w_onehot = CNT'(1) << w_winner;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_gnt_vld_nxt = r_gnt_vld;
    w_err_nxt     = r_err;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt   = ST_BUSY;
          w_gnt_nxt     = w_onehot;
          w_gnt_id_nxt  = w_winner;
          w_gnt_vld_nxt = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_release) begin
          w_ptr_nxt = w_ptr_rel;
          if (|req) begin
            w_gnt_nxt     = w_onehot;
            w_gnt_id_nxt  = w_winner;
            w_gnt_vld_nxt = 1'b1;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_gnt_nxt     = '0;
            w_gnt_id_nxt  = '0;
            w_gnt_vld_nxt = 1'b0;
          end
        end else if (~|(req & r_gnt)) begin
          // Owner let go of req before its final beat was acked.
          w_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_gnt_nxt     = '0;
        w_gnt_id_nxt  = '0;
        w_gnt_vld_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_gnt_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_gnt_vld <= w_gnt_vld_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_vld = r_gnt_vld;
  assign gnt_id  = r_gnt_id;
  assign err     = r_err;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Testbench for rr_sel_arbiter: directed scenarios followed by random traffic,
// with expected outputs produced by a transaction-level round-robin model and
// checked through a scoreboard queue by an independent monitor.
module tb_rr_sel_arbiter;

  localparam int unsigned CNT = 5;
  localparam int unsigned IDW = 3;

  typedef struct packed {
    logic [CNT-1:0] gnt;
    logic [IDW-1:0] id;
    logic           vld;
    logic           err;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [CNT-1:0] req;
  logic           ack;
  logic           eop;
  logic [CNT-1:0] gnt;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic           err;

  int n_checks;
  int n_pass;

  exp_t sb_q[$];

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  bit m_err;

  rr_sel_arbiter #(.CNT(CNT), .IDW(IDW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .ack     (ack),
    .eop     (eop),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Circular scan starting at the priority pointer.
  function automatic int pick(input logic [CNT-1:0] r, input int p);
    for (int k = 0; k < CNT; k++) begin
      if (r[(p + k) % CNT]) return (p + k) % CNT;
    end
    return -1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt = m_busy ? CNT'(1) << m_owner : '0;
    e.id  = m_busy ? IDW'(m_owner) : '0;
    e.vld = m_busy;
    e.err = m_err;
    return e;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_err   = 0;
  endtask

  // One clock of the transaction-level model for the inputs about to be sampled.
  task automatic model_step(input logic [CNT-1:0] r, input logic a, input logic e);
    if (!m_busy) begin
      if (r != '0) begin
        m_owner = pick(r, m_ptr);
        m_busy  = 1;
      end
    end else if (a && e) begin
      m_ptr = (m_owner + 1) % CNT;
      if (r != '0) m_owner = pick(r, m_ptr);
      else m_busy = 0;
    end else if (!r[m_owner]) begin
      m_err = 1;
    end
  endtask

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic drive(input logic [CNT-1:0] r, input logic a, input logic e);
    @(negedge clk);
    req = r;
    ack = a;
    eop = e;
    model_step(r, a, e);
    sb_q.push_back(model_out());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
  endtask

  // Monitor: each clock the DUT presents a response; compare it with the queue head.
  always @(posedge clk) begin
    exp_t e;
    exp_t got;
    #1;
    if (rst_n && sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = '{gnt: gnt, id: gnt_id, vld: gnt_vld, err: err};
      check("outputs{gnt,id,vld,err}", 32'(got), 32'(e));
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CNT-1:0] r;
    logic a;
    logic e;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    req   = '0;
    ack   = 1'b0;
    eop   = 1'b0;
    model_reset();
    #12;
    check("reset_state", 32'({gnt, gnt_id, gnt_vld, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests
    repeat (5) drive('0, 1'b0, 1'b0);

    // Multi-beat hold then no-bubble handover 2 -> 4
    drive(5'b10100, 1'b0, 1'b0);
    repeat (3) drive(5'b10100, 1'b1, 1'b0);
    drive(5'b10100, 1'b1, 1'b1);
    drive(5'b00000, 1'b1, 1'b1);

    // All requesting: order 0,1,2,3,4,0
    drive(5'b11111, 1'b0, 1'b0);
    repeat (5) drive(5'b11111, 1'b1, 1'b1);
    drive(5'b00000, 1'b1, 1'b1);

    // Sole requester re-granted on every release
    drive(5'b01000, 1'b0, 1'b0);
    repeat (3) drive(5'b01000, 1'b1, 1'b1);
    drive(5'b00000, 1'b1, 1'b1);

    // Owner 1 drops req early: sticky err, grant held until release
    drive(5'b00010, 1'b0, 1'b0);
    drive(5'b00000, 1'b0, 1'b0);
    drive(5'b00000, 1'b1, 1'b0);
    drive(5'b00000, 1'b1, 1'b1);
    repeat (2) drive(5'b00000, 1'b0, 1'b0);

    // Asynchronous reset while busy with requester 3
    drive(5'b01000, 1'b0, 1'b0);
    drive(5'b01000, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("async_reset_gnt_vld", 32'({gnt, gnt_vld}), 32'd0);
    check("async_reset_err", 32'(err), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'b11111, 1'b0, 1'b0);
    drive(5'b11111, 1'b1, 1'b1);
    drive(5'b00000, 1'b1, 1'b1);

    // Random traffic; owner mostly honours the hold rule
    for (int n = 0; n < 400; n++) begin
      r = CNT'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      if (m_busy && $urandom_range(0, 63) != 0) r[m_owner] = 1'b1;
      a = ($urandom_range(0, 1) == 1);
      e = ($urandom_range(0, 2) == 0);
      drive(r, a, e);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
